// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core/host/memory signal bundle around the data memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              host_req;
  logic              host_we;
  logic              host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_locked;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    output host_gnt, host_rvalid, host_rdata, host_locked,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    input  host_gnt, host_rvalid, host_rdata, host_locked,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core-priority arbiter with host wait guarantee and lock mode for the data memory
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input logic          clk,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {OPEN, LOCKED} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              host_locked_q;
  logic              core_rvalid_q;
  logic              host_rvalid_q;

  logic              core_gnt;
  logic              host_gnt;
  logic              mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  // Combinational arbitration; everything is forced idle while reset is held.
  always_comb begin
    host_gnt = 1'b0;
    core_gnt = 1'b0;
    if (reset_n) begin
      if (state == LOCKED) begin
        host_gnt = bus.host_req;
      end else begin
        host_gnt = bus.host_req & (~bus.core_req | (wait_cnt == WAIT_MAX));
        core_gnt = bus.core_req & ~host_gnt;
      end
    end
  end

  // Steer the winner's payload onto the memory pins; idle pins read as zero.
  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (host_gnt) begin
      mux_we    = bus.host_we;
      mux_addr  = bus.host_addr;
      mux_wdata = bus.host_wdata;
    end else if (core_gnt) begin
      mux_we    = bus.core_we;
      mux_addr  = bus.core_addr;
      mux_wdata = bus.core_wdata;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.core_stall  = reset_n & bus.core_req & ~core_gnt;
  assign bus.host_locked = host_locked_q;
  assign bus.mem_en      = core_gnt | host_gnt;
  assign bus.mem_we      = mux_we;
  assign bus.mem_addr    = mux_addr;
  assign bus.mem_wdata   = mux_wdata;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  // Read data is shared; each consumer qualifies it with its own rvalid.
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;

  // Lock FSM, host starvation counter and one-cycle read response owner flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= OPEN;
      wait_cnt      <= 4'd0;
      host_locked_q <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      core_rvalid_q <= core_gnt & ~bus.core_we;
      host_rvalid_q <= host_gnt & ~bus.host_we;

      if (host_gnt || !bus.host_req) begin
        wait_cnt <= 4'd0;
      end else if (core_gnt && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      case (state)
        OPEN: begin
          if (host_gnt && bus.host_lock) begin
            state         <= LOCKED;
            host_locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          // Leave on the last beat (lock dropped) or when the host abandons.
          if (!bus.host_req || !bus.host_lock) begin
            state         <= OPEN;
            host_locked_q <= 1'b0;
          end
        end
        default: begin
          state         <= OPEN;
          host_locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the pipeline's single 256x8 data memory between the core's EX-stage load/store port and a host/debug port. The core has fixed priority. A wait counter guarantees the host a slot after MAX_WAIT contended cycles, and a lock mode gives the host exclusive multi-beat access. It sits between the pipeline datapath and the synchronous-read data memory. It owns the memory's enable, write-enable, address and write-data pins, and steers read data back to the requester.

## Interface
- MAX_WAIT, 4: contended host cycles before a forced host grant; legal range 1..15.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.

- clk  in  1  Single clock; all state updates on the rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- core_req / core_we  in  1 / 1  Core access request / write (1) or read (0).
- core_addr / core_wdata  in  ADDR_W / DATA_W  Core address / write data.
- core_gnt  out  1  Core access accepted this cycle.
- core_rvalid / core_rdata  out  1 / DATA_W  Core read response.
- host_req / host_we / host_lock  in  1 / 1 / 1  Host request / write / hold lock after this beat.
- host_addr / host_wdata  in  ADDR_W / DATA_W  Host address / write data.
- host_gnt  out  1  Host access accepted this cycle.
- host_rvalid / host_rdata  out  1 / DATA_W  Host read response.
- mem_en / mem_we  out  1 / 1  Memory access strobe / write strobe.
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  Memory address / write data.
- mem_rdata  in  DATA_W  Memory read data, valid the cycle after a read strobe.
- core_stall  out  1  core_req & ~core_gnt; drives pipeline freeze.
- host_locked  out  1  High while in LOCKED.

## Operation
- Handshake: a requester holds req and its payload stable until it sees gnt high. A transfer occurs on any edge where req & gnt.
- States: OPEN (reset) and LOCKED.
- Grant rule in OPEN:
  - host_gnt = host_req & (~core_req | wait_cnt == MAX_WAIT).
  - core_gnt = core_req & ~host_gnt.
- Grant rule in LOCKED:
  - host_gnt = host_req.
  - core_gnt = 0.
- wait_cnt (4 bits): resets to 0.
  - Clears on any edge where host_gnt = 1 or host_req = 0.
  - Otherwise increments when host_req & core_gnt, saturating at MAX_WAIT.
- OPEN -> LOCKED: edge where host_req & host_gnt & host_lock.
- LOCKED -> OPEN: edge where host_req & host_lock = 0 (last beat), or host_req = 0 (abandon).
- Memory mux: winner's addr/we/wdata drive mem_*. mem_en = core_gnt | host_gnt. With no grant, mem_we = 0 and addr/wdata = 0.
- Read return: on a read transfer, register owner (core/host) and a pending flag.
  - Next cycle, the owner's rvalid = 1 for one cycle.
  - Both core_rdata and host_rdata = mem_rdata at all times; consumers qualify with rvalid.
- Writes produce no response.
- Reset asserted (any time): all gnt, mem_en, mem_we, rvalid, core_stall, host_locked = 0. State = OPEN, wait_cnt = 0, pending read dropped.

## Timing
- Arbitration is combinational: gnt is valid in the same cycle as req (0-cycle latency).
- Read latency is 1 cycle from the grant edge to rvalid.
- Throughput is one access per cycle. Back-to-back reads by alternating owners return in grant order with no bubble.
- Host worst-case wait in OPEN under continuous core traffic: granted in the (MAX_WAIT+1)th cycle of its request. Core then wins the following cycle.
- Core is stalled for the entire LOCKED period. There is no lock timeout; host firmware bounds it.
- Simultaneous events:
  - Forced host grant and core request in the same cycle: host wins, and core_stall = 1 for that cycle.
  - Exit-lock beat and core request in the same cycle: host wins that beat; core is granted next cycle.
- Reset deasserting mid-burst leaves the block in OPEN. A held host_lock takes effect only on the next host grant.

## Test plan
- Core-only traffic: write 0x5A to 0x10, then read 0x10 -> core_gnt same cycle each; core_rvalid = 1 with core_rdata = 0x5A one cycle after the read grant; host_rvalid stays 0.
- Contention, MAX_WAIT=4: core_req held high, host read 0x20 asserted at cycle 0 -> core_gnt cycles 0-3, host_gnt at cycle 4, core_stall = 1 at cycle 4, core_gnt resumes at cycle 5.
- Lock burst: host writes 0x30, 0x31, 0x32 with host_lock = 1,1,0 while core_req is held -> host_locked high from the edge after beat 1 through beat 3; core_gnt = 0 throughout; core granted the cycle after beat 3.
- Interleaved reads: core reads 0x01 (data 0xAA) at cycle 0, forced host read 0x02 (data 0xBB) at cycle 1 -> core_rvalid at cycle 1, host_rvalid at cycle 2 with the correct data each.
- Reset mid-read: assert reset_n = 0 between a read grant and its response -> no rvalid appears, all outputs 0 during reset; after release, state is OPEN with wait_cnt = 0.
- Abandoned lock: host_lock = 1 beat, then host_req drops -> return to OPEN next edge; core granted.
